// File: rtl/cache_pkg.sv
// cache_pkg: controller state encoding, memory command codes and address field-width helpers
package cache_pkg;
  typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL_REQ, REFILL_WAIT, RESPOND} state_e;
  localparam logic MEM_READ = 1'b0;
  localparam logic MEM_WRITE = 1'b1;
  function automatic int clog2(input int v);
    int r = 0;
    for (int p = 1; p < v; p = p * 2) r++;
    return r;
  endfunction
  function automatic int off_w(input int words);
    return clog2(words * 4);
  endfunction
  function automatic int idx_w(input int sets);
    return clog2(sets);
  endfunction
  function automatic int tag_w(input int addr_w, input int sets, input int words);
    return addr_w - idx_w(sets) - off_w(words);
  endfunction
endpackage

// File: rtl/cache_lru_tracker.sv
// cache_lru_tracker: per-set true-LRU ages (0 = most recent) and the oldest way of the addressed set
module cache_lru_tracker
  import cache_pkg::*;
#(
  parameter int WAYS = 2,
  parameter int SETS = 2,
  parameter int WW = (WAYS > 1) ? clog2(WAYS) : 1,
  parameter int IW = (SETS > 1) ? clog2(SETS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [IW-1:0] set_i,
  input  logic [WW-1:0] way_i,
  input  logic          access_i,
  output logic [WW-1:0] victim_o
);
  logic [WW-1:0] age_q [SETS][WAYS];
  logic [WW-1:0] age_d [WAYS];
  always_comb begin
    for (int w = 0; w < WAYS; w++)
      age_d[w] = (WW'(w) == way_i) ? '0 :
                 (age_q[set_i][w] < age_q[set_i][way_i]) ? age_q[set_i][w] + 1'b1 : age_q[set_i][w];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= WW'(w);
    end else if (access_i) begin
      for (int w = 0; w < WAYS; w++) age_q[set_i][w] <= age_d[w];
    end
  end
  always_comb begin
    victim_o = '0;
    for (int w = 0; w < WAYS; w++)
      if (age_q[set_i][w] == WW'(WAYS - 1)) victim_o = WW'(w);
  end
endmodule

// File: rtl/cache_assoc_wb.sv
// cache_assoc_wb: N-way set-associative write-back, write-allocate byte cache with handshaked CPU and memory ports
module cache_assoc_wb
  import cache_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int WAYS = 2,
  parameter int SETS = 2,
  parameter int WORDS = 4,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cpu_req_valid,
  output logic                cpu_req_ready,
  input  logic                cpu_rw,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [7:0]          cpu_wdata,
  output logic                cpu_resp_valid,
  output logic [7:0]          cpu_rdata,
  output logic                cpu_hit,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_rw,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [WORDS*32-1:0] mem_wdata,
  input  logic                mem_resp_valid,
  input  logic [WORDS*32-1:0] mem_rdata,
  output logic [CNT_W-1:0]    hit_count,
  output logic [CNT_W-1:0]    miss_count
);
  localparam int OFF_W = off_w(WORDS);
  localparam int IDX_W = idx_w(SETS);
  localparam int TAG_W = tag_w(ADDR_W, SETS, WORDS);
  localparam int IW = (IDX_W > 0) ? IDX_W : 1;
  localparam int WW = (WAYS > 1) ? clog2(WAYS) : 1;
  localparam int BW = WORDS * 32;
  state_e state_q, state_d;
  logic rw_q, hit_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0] wdata_q, rdata_q;
  logic [CNT_W-1:0] hits_q, misses_q;
  logic [WW-1:0] victim_q, hit_way, inv_way, lru_way, victim, acc_way;
  logic hit, inv, acc;
  logic valid_q [SETS][WAYS];
  logic dirty_q [SETS][WAYS];
  logic [TAG_W-1:0] tag_q [SETS][WAYS];
  logic [BW-1:0] data_q [SETS][WAYS];
  logic [TAG_W-1:0] tag;
  logic [IW-1:0] idx;
  logic [OFF_W+2:0] sh;
  assign tag = addr_q[ADDR_W-1 -: TAG_W];
  assign idx = (SETS > 1) ? addr_q[OFF_W +: IW] : '0;
  // byte 0 sits at the MSBs, so the right-shift for byte k is 8*(bytes-1-k)
  assign sh = {~addr_q[OFF_W-1:0], 3'b000};
  function automatic logic [ADDR_W-1:0] blk_addr(input logic [TAG_W-1:0] t, input logic [IW-1:0] i);
    return {t, {(ADDR_W - TAG_W){1'b0}}} | ((SETS > 1) ? ADDR_W'(i) << OFF_W : '0);
  endfunction
  function automatic logic [BW-1:0] put_byte(input logic [BW-1:0] blk, input logic [OFF_W+2:0] s,
                                             input logic [7:0] b);
    return (blk & ~(BW'(8'hFF) << s)) | (BW'(b) << s);
  endfunction
  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    inv = 1'b0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
        hit = 1'b1;
        hit_way = WW'(w);
      end
      if (!valid_q[idx][w]) begin
        inv = 1'b1;
        inv_way = WW'(w);
      end
    end
  end
  assign victim = inv ? inv_way : lru_way;
  assign acc = (state_q == LOOKUP && hit) || (state_q == REFILL_WAIT && mem_resp_valid);
  assign acc_way = (state_q == LOOKUP) ? hit_way : victim_q;
  cache_lru_tracker #(.WAYS(WAYS), .SETS(SETS), .WW(WW), .IW(IW)) u_lru (
    .clk(clk), .reset(reset), .set_i(idx), .way_i(acc_way), .access_i(acc), .victim_o(lru_way)
  );
  always_ff @(posedge clk) state_q <= reset ? IDLE : state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:        if (cpu_req_valid) state_d = LOOKUP;
      LOOKUP:      state_d = hit ? RESPOND :
                             (valid_q[idx][victim] && dirty_q[idx][victim]) ? WRITEBACK : REFILL_REQ;
      WRITEBACK:   if (mem_req_ready) state_d = REFILL_REQ;
      REFILL_REQ:  if (mem_req_ready) state_d = REFILL_WAIT;
      REFILL_WAIT: if (mem_resp_valid) state_d = RESPOND;
      default:     state_d = IDLE;
    endcase
  end
  always_comb begin
    cpu_req_ready = state_q == IDLE;
    cpu_resp_valid = state_q == RESPOND;
    mem_req_valid = state_q == WRITEBACK || state_q == REFILL_REQ;
    mem_rw = (state_q == WRITEBACK) ? MEM_WRITE : MEM_READ;
    mem_addr = (state_q == WRITEBACK) ? blk_addr(tag_q[idx][victim_q], idx) :
               (state_q == REFILL_REQ) ? blk_addr(tag, idx) : '0;
    mem_wdata = (state_q == WRITEBACK) ? data_q[idx][victim_q] : '0;
  end
  assign cpu_rdata = rdata_q;
  assign cpu_hit = hit_q;
  assign hit_count = hits_q;
  assign miss_count = misses_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
        end
      rw_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      hit_q <= 1'b0;
      hits_q <= '0;
      misses_q <= '0;
      victim_q <= '0;
    end else begin
      if (state_q == IDLE && cpu_req_valid) begin
        rw_q <= cpu_rw;
        addr_q <= cpu_addr;
        wdata_q <= cpu_wdata;
      end
      if (state_q == LOOKUP) begin
        hit_q <= hit;
        victim_q <= victim;
        if (hit && rw_q) begin
          data_q[idx][hit_way] <= put_byte(data_q[idx][hit_way], sh, wdata_q);
          dirty_q[idx][hit_way] <= 1'b1;
        end
        if (hit && !rw_q) rdata_q <= 8'(data_q[idx][hit_way] >> sh);
        if (hit && ~&hits_q) hits_q <= hits_q + 1'b1;
        if (!hit && ~&misses_q) misses_q <= misses_q + 1'b1;
      end
      if (state_q == REFILL_WAIT && mem_resp_valid) begin
        data_q[idx][victim_q] <= rw_q ? put_byte(mem_rdata, sh, wdata_q) : mem_rdata;
        tag_q[idx][victim_q] <= tag;
        valid_q[idx][victim_q] <= 1'b1;
        dirty_q[idx][victim_q] <= rw_q;
        if (!rw_q) rdata_q <= 8'(mem_rdata >> sh);
      end
    end
  end
endmodule

// File: doc/cache_assoc_wb.md
Name: cache_assoc_wb

Overview:
Clocked, parametrised N-way set-associative write-back, write-allocate data cache between the byte-addressed CPU port and the block-wide main memory port.
- Successor to the combinational 2-way cache: adds a clock, valid/ready handshakes on both sides, configurable geometry, true LRU for any way count, and hit/miss counters.
- Sits between the CPU data path and the main memory model.

Parameters:
ADDR_W, 10, byte address width
WAYS, 2, associativity (power of 2, >=1)
SETS, 2, number of sets (power of 2, >=1)
WORDS, 4, 32-bit words per block (power of 2); block = WORDS*32 bits
CNT_W, 16, width of hit/miss counters

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
cpu_req_valid  in  1  CPU request present
cpu_req_ready  out  1  cache accepts request (high only in IDLE)
cpu_rw  in  1  0 read, 1 write
cpu_addr  in  ADDR_W  byte address: tag | set index | word offset | byte offset
cpu_wdata  in  8  write byte
cpu_resp_valid  out  1  one-cycle pulse: request complete
cpu_rdata  out  8  read byte, valid with cpu_resp_valid
cpu_hit  out  1  request hit, valid with cpu_resp_valid
mem_req_valid  out  1  memory request
mem_req_ready  in  1  memory accepts request
mem_rw  out  1  0 refill read, 1 write-back
mem_addr  out  ADDR_W  block-aligned address (offset bits zero)
mem_wdata  out  WORDS*32  write-back block
mem_resp_valid  in  1  refill data present
mem_rdata  in  WORDS*32  refill block
hit_count  out  CNT_W  saturating hit counter
miss_count  out  CNT_W  saturating miss counter

Behaviour:
- Field widths: OFF_W = log2(WORDS*4); IDX_W = log2(SETS), 0 when SETS=1; TAG_W = ADDR_W-IDX_W-OFF_W.
- Byte layout: byte 0 of a block at MSBs [WORDS*32-1 -: 8], byte k at [WORDS*32-1-8k -: 8] (big-endian, as in the existing cache).
- Per line: valid, dirty, tag, data. Per set: age[WAYS] of log2(WAYS) bits; 0 = MRU.
- Reset:
  - All valid/dirty bits cleared; ages set to way index; state IDLE.
  - Outputs: cpu_req_ready=1, cpu_resp_valid=0, cpu_rdata=0, cpu_hit=0, mem_req_valid=0, mem_rw=0, mem_addr=0, mem_wdata=0, counters=0.
  - Reset mid-miss aborts immediately: mem_req_valid low the next cycle; no partial line is kept.
- FSM states: IDLE, LOOKUP, WRITEBACK, REFILL_REQ, REFILL_WAIT, RESPOND.
- IDLE: on cpu_req_valid && cpu_req_ready, latch rw/addr/wdata and go to LOOKUP. cpu_req_ready=0 in every other state.
- LOOKUP:
  - Compare all ways of the set.
  - Hit: perform the byte read or write (write sets dirty), update LRU, increment hit_count, go to RESPOND.
  - Miss: increment miss_count and select victim = lowest-index invalid way, else the way with maximum age.
  - Victim valid && dirty -> WRITEBACK; otherwise -> REFILL_REQ.
- WRITEBACK: mem_req_valid=1, mem_rw=1, mem_addr={victim tag, index, 0}, mem_wdata=victim data. All held stable until the cycle mem_req_ready=1, then -> REFILL_REQ.
- REFILL_REQ: mem_req_valid=1, mem_rw=0, mem_addr={tag, index, 0}. On mem_req_ready -> REFILL_WAIT.
- REFILL_WAIT:
  - On mem_resp_valid, install mem_rdata, tag, valid=1, dirty=0 in the victim way.
  - Then apply the pending write byte (dirty=1) or read the byte; update LRU; -> RESPOND.
- RESPOND: cpu_resp_valid=1 for exactly one cycle with cpu_rdata (reads; holds last value on writes) and cpu_hit; -> IDLE.
- Latency from the accepting edge: hit = 2 cycles to cpu_resp_valid. Clean miss = 2 + memory handshake cycles; dirty miss adds the write-back handshake.
- LRU update on access to way w with old age a: every way with age < a increments; way w becomes 0. Ages stay a permutation of 0..WAYS-1. WAYS=1 degenerates to direct-mapped.
- Counters saturate at all-ones; no wrap.
- mem_resp_valid outside REFILL_WAIT is ignored. mem_req_ready outside WRITEBACK/REFILL_REQ is ignored.

Decomposition:
- Package cache_pkg: state enum (the six states), functions clog2 and field-width helpers (tag/index/offset), MEM_READ/MEM_WRITE constants.
- One sub-module, cache_lru_tracker:
  - Per-set age arrays, reset to way index.
  - Inputs: set index, access way, access strobe.
  - Output: victim way for a given set.
- Tag/data arrays and FSM stay in cache_assoc_wb.

Test Plan:
1. Reset, then read 0x014 (set 1, tag 0), memory returns block with byte 4 = 0x5C -> miss, one REFILL read at mem_addr 0x010, cpu_rdata=0x5C, cpu_hit=0, miss_count=1.
2. Read 0x014 again -> cpu_resp_valid exactly 2 cycles after accept, cpu_hit=1, no mem_req_valid, hit_count=1.
3. Write 0xAB to 0x015, then reads 0x034, 0x054 (same set, tags 1, 2; defaults) -> third access evicts tag 0: write-back at mem_addr 0x010 with byte 5 = 0xAB, then refill 0x050.
4. Hold mem_req_ready=0 for 5 cycles during a write-back -> mem_req_valid, mem_addr, mem_wdata stable all 5 cycles; cpu_req_ready=0 throughout.
5. Assert reset in REFILL_WAIT -> next cycle mem_req_valid=0, cpu_req_ready=1; re-reading the address misses.
6. WAYS=4, SETS=1: access tags 0,1,2,3,0, then a new tag 4 -> victim is the tag-1 way; after preloading counters to all-ones, a hit leaves hit_count at all-ones.
